// File: rtl/fft_calculator_if.sv
// Sample/result bundle for the 8-point DFT engine: eight signed samples with a
// start strobe in, sixteen signed result words with a completion pulse out.
interface fft_calculator_if;
    logic               iStart;
    logic signed [7:0]  iSamples0, iSamples1, iSamples2, iSamples3;
    logic signed [7:0]  iSamples4, iSamples5, iSamples6, iSamples7;
    logic signed [19:0] oResult0,  oResult1,  oResult2,  oResult3;
    logic signed [19:0] oResult4,  oResult5,  oResult6,  oResult7;
    logic signed [19:0] oResult8,  oResult9,  oResult10, oResult11;
    logic signed [19:0] oResult12, oResult13, oResult14, oResult15;
    logic               oDone;

    modport master (
        output iStart,
        output iSamples0, iSamples1, iSamples2, iSamples3,
        output iSamples4, iSamples5, iSamples6, iSamples7,
        input  oResult0,  oResult1,  oResult2,  oResult3,
        input  oResult4,  oResult5,  oResult6,  oResult7,
        input  oResult8,  oResult9,  oResult10, oResult11,
        input  oResult12, oResult13, oResult14, oResult15,
        input  oDone
    );

    modport slave (
        input  iStart,
        input  iSamples0, iSamples1, iSamples2, iSamples3,
        input  iSamples4, iSamples5, iSamples6, iSamples7,
        output oResult0,  oResult1,  oResult2,  oResult3,
        output oResult4,  oResult5,  oResult6,  oResult7,
        output oResult8,  oResult9,  oResult10, oResult11,
        output oResult12, oResult13, oResult14, oResult15,
        output oDone
    );
endinterface

// File: rtl/fft_calculator.sv
// Fully pipelined 8-point DFT with Q8 twiddles: capture, first butterfly,
// constant-twiddle products, per-bin accumulation into the output registers.
module fft_calculator (
    input  logic            Clock,
    input  logic            Reset,
    fft_calculator_if.slave bus
);
    logic signed [7:0]  w_x   [8];
    logic signed [7:0]  r_x   [8];
    logic signed [8:0]  r_a   [4];
    logic signed [8:0]  r_b   [4];
    logic signed [19:0] w_re  [8];
    logic signed [19:0] w_im  [8];
    logic               r_v0, r_v1, r_v2, r_done;

    assign w_x[0] = bus.iSamples0;
    assign w_x[1] = bus.iSamples1;
    assign w_x[2] = bus.iSamples2;
    assign w_x[3] = bus.iSamples3;
    assign w_x[4] = bus.iSamples4;
    assign w_x[5] = bus.iSamples5;
    assign w_x[6] = bus.iSamples6;
    assign w_x[7] = bus.iSamples7;

    function automatic int cos_q(input int m);
        case (m % 8)
            0:       return 256;
            1:       return 181;
            2:       return 0;
            3:       return -181;
            4:       return -256;
            5:       return -181;
            6:       return 0;
            default: return 181;
        endcase
    endfunction

    function automatic int sin_q(input int m);
        return cos_q(m + 6);
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_v0   <= bus.iStart;
            r_v1   <= r_v0;
            r_v2   <= r_v1;
            r_done <= r_v2;
        end
    end

    always_ff @(posedge Clock) begin
        if (bus.iStart) begin
            r_x <= w_x;
        end
    end

    // x[n+4] sees twiddle W^(nk) for even k and -W^(nk) for odd k, so the
    // sum/difference split keeps every product on an exact Q8 twiddle.
    always_ff @(posedge Clock) begin
        for (int n = 0; n < 4; n++) begin
            r_a[n] <= 9'(r_x[n]) + 9'(r_x[n + 4]);
            r_b[n] <= 9'(r_x[n]) - 9'(r_x[n + 4]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bin
            logic signed [8:0]  w_s    [4];
            logic signed [17:0] r_p_re [4];
            logic signed [17:0] r_p_im [4];
            logic signed [19:0] r_re, r_im;

            if (gi % 2 == 0) begin : g_even
                assign w_s = r_a;
            end else begin : g_odd
                assign w_s = r_b;
            end

            always_ff @(posedge Clock) begin
                for (int n = 0; n < 4; n++) begin
                    r_p_re[n] <= 18'(w_s[n]) * 18'(cos_q(n * gi));
                    r_p_im[n] <= 18'(w_s[n]) * 18'(-sin_q(n * gi));
                end
                if (Reset) begin
                    r_re <= '0;
                    r_im <= '0;
                end else if (r_v2) begin
                    r_re <= 20'(r_p_re[0]) + 20'(r_p_re[1]) + 20'(r_p_re[2]) + 20'(r_p_re[3]);
                    r_im <= 20'(r_p_im[0]) + 20'(r_p_im[1]) + 20'(r_p_im[2]) + 20'(r_p_im[3]);
                end
            end

            assign w_re[gi] = r_re;
            assign w_im[gi] = r_im;
        end
    endgenerate

    assign bus.oResult0  = w_re[0];
    assign bus.oResult1  = w_im[0];
    assign bus.oResult2  = w_re[1];
    assign bus.oResult3  = w_im[1];
    assign bus.oResult4  = w_re[2];
    assign bus.oResult5  = w_im[2];
    assign bus.oResult6  = w_re[3];
    assign bus.oResult7  = w_im[3];
    assign bus.oResult8  = w_re[4];
    assign bus.oResult9  = w_im[4];
    assign bus.oResult10 = w_re[5];
    assign bus.oResult11 = w_im[5];
    assign bus.oResult12 = w_re[6];
    assign bus.oResult13 = w_im[6];
    assign bus.oResult14 = w_re[7];
    assign bus.oResult15 = w_im[7];
    assign bus.oDone     = r_done;
endmodule

// File: tb/tb_fft_calculator.sv
// Randomised and directed bench for fft_calculator against a floating-point
// derived Q8 DFT model with a latency-tagged scoreboard.
module tb_fft_calculator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_calculator_if bus ();
    fft_calculator dut (.Clock(clk), .Reset(rst), .bus(bus));

    typedef struct {
        int due;
        int res [16];
    } exp_t;

    exp_t q [$];
    int   last [16];
    int   smp [8];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int qtw(input real v);
        return $rtoi(v * 256.0 + ((v >= 0.0) ? 0.5 : -0.5));
    endfunction

    function automatic exp_t dft(input int x [8], input int due);
        exp_t e;
        real  ang;
        e.due = due;
        for (int k = 0; k < 8; k++) begin
            int re = 0;
            int im = 0;
            for (int n = 0; n < 8; n++) begin
                ang = 2.0 * 3.14159265358979323846 * real'(n * k) / 8.0;
                re += x[n] * qtw($cos(ang));
                im -= x[n] * qtw($sin(ang));
            end
            e.res[2 * k]     = re;
            e.res[2 * k + 1] = im;
        end
        return e;
    endfunction

    // Model side: the capture edge defines when the result is due.
    always @(posedge clk) begin
        int x [8];
        cyc++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) last[i] = 0;
        end else if (bus.iStart) begin
            x[0] = bus.iSamples0; x[1] = bus.iSamples1;
            x[2] = bus.iSamples2; x[3] = bus.iSamples3;
            x[4] = bus.iSamples4; x[5] = bus.iSamples5;
            x[6] = bus.iSamples6; x[7] = bus.iSamples7;
            q.push_back(dft(x, cyc + 3));
        end
    end

    always @(negedge clk) begin
        int   obs [16];
        logic exp_done;
        obs[0]  = bus.oResult0;  obs[1]  = bus.oResult1;
        obs[2]  = bus.oResult2;  obs[3]  = bus.oResult3;
        obs[4]  = bus.oResult4;  obs[5]  = bus.oResult5;
        obs[6]  = bus.oResult6;  obs[7]  = bus.oResult7;
        obs[8]  = bus.oResult8;  obs[9]  = bus.oResult9;
        obs[10] = bus.oResult10; obs[11] = bus.oResult11;
        obs[12] = bus.oResult12; obs[13] = bus.oResult13;
        obs[14] = bus.oResult14; obs[15] = bus.oResult15;
        exp_done = (q.size() > 0) && (q[0].due == cyc);
        check_val("oDone", int'(bus.oDone), int'(exp_done));
        if (exp_done) begin
            last = q[0].res;
            void'(q.pop_front());
        end
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("oResult%0d", i), obs[i], last[i]);
        end
    end

    task automatic step(input logic st, input logic rs);
        rst           = rs;
        bus.iStart    = st;
        bus.iSamples0 = 8'(smp[0]);
        bus.iSamples1 = 8'(smp[1]);
        bus.iSamples2 = 8'(smp[2]);
        bus.iSamples3 = 8'(smp[3]);
        bus.iSamples4 = 8'(smp[4]);
        bus.iSamples5 = 8'(smp[5]);
        bus.iSamples6 = 8'(smp[6]);
        bus.iSamples7 = 8'(smp[7]);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_smp();
        for (int i = 0; i < 8; i++) smp[i] = int'($signed(8'($urandom)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rand_smp();
            step(1'b0, 1'b0);
        end
    endtask

    initial begin
        rand_smp();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(4);

        smp = '{2, 5, -2, 0, 1, -4, 3, 2};
        step(1'b1, 1'b0);
        idle(5);

        smp = '{-128, -128, -128, -128, -128, -128, -128, -128};
        step(1'b1, 1'b0);
        idle(5);

        smp = '{127, 0, 0, 0, 0, 0, 0, 0};
        step(1'b1, 1'b0);
        idle(5);

        for (int i = 0; i < 3; i++) begin
            rand_smp();
            step(1'b1, 1'b0);
        end
        idle(5);

        rand_smp();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle(5);
        rand_smp();
        step(1'b1, 1'b0);
        idle(5);

        rand_smp();
        step(1'b1, 1'b1);
        idle(5);

        for (int i = 0; i < 250; i++) begin
            rand_smp();
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_calculator.md
FFT_CALCULATOR -- requirements
Module: fft_calculator

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port Clock SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port Reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port iStart SHALL be an input, 1 bit: capture the samples on this edge.
REQ-006 Ports iSamples0..iSamples7 SHALL be inputs, 8 bits each: signed two's-complement time samples x[0]..x[7].
REQ-007 Ports oResult0..oResult15 SHALL be outputs, 20 bits each, signed two's-complement: oResult(2k) = Re(X[k]) and oResult(2k+1) = Im(X[k]), for k = 0..7.
REQ-008 Port oDone SHALL be an output, 1 bit: one-cycle pulse, high when a new result set appears on oResult*.

Function
REQ-009 The block SHALL compute the 8-point DFT X[k] = sum over n of x[n]*exp(-j*2*pi*n*k/8), scaled by 256.
REQ-010 Arithmetic SHALL be exact integer; results use Q8 fixed-point twiddles (cos and sin each in {0, +/-256, +/-181}).
- Re = sum x[n]*round(256*cos(2*pi*n*k/8))
- Im = -sum x[n]*round(256*sin(2*pi*n*k/8))
- No rounding or truncation beyond the twiddle quantisation.
REQ-011 Internal widths SHALL prevent overflow. Maximum magnitude is 8*128*256 = 262144, which fits 20 bits signed; outputs are never saturated.
REQ-012 Any radix-2 (DIT or DIF) or direct structure is allowed, provided outputs are bit-exact to REQ-010.
REQ-013 On a rising edge with iStart=1 and Reset=0, iSamples0..7 SHALL be registered (capture edge C).
REQ-014 Latency SHALL be fixed:
- The result set for capture edge C appears on oResult* after edge C+3.
- oDone is high for exactly the cycle following edge C+3.
REQ-015 The datapath SHALL be fully pipelined.
- iStart may be asserted every cycle.
- Each capture produces exactly one oDone pulse, in order.
- Back-to-back captures give consecutive oDone cycles.
REQ-016 Input changes while iStart=0 SHALL have no effect.
REQ-017 oResult* SHALL hold the last completed result set until the next completion.
REQ-018 oResult* SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-019 When Reset=1 at a rising edge, the following SHALL clear:
- all oResult* to 0
- oDone to 0
- all internal pipeline valid flags
REQ-020 Reset SHALL take priority over iStart. A capture on a reset edge is ignored.
REQ-021 Reset mid-operation SHALL discard every in-flight computation. No oDone may follow for captures made before reset.
REQ-022 After reset deasserts, the first capture SHALL produce its result at the normal latency (REQ-014).

Verification
REQ-023 Reset: hold Reset=1 for 2 cycles -> all oResult* = 0 and oDone = 0; outputs stay 0 with iStart=0.
REQ-024 Samples 2,5,-2,0,1,-4,3,2 captured at edge C -> oDone is high after C+3, with (Re,Im) per bin:
- X0 = (1792, 0)
- X1 = (2247, 13)
- X2 = (512, 256)
- X3 = (-1735, -2547)
- X4 = (256, 0)
- X5 = (-1735, 2547)
- X6 = (512, -256)
- X7 = (2247, -13)
REQ-025 All samples = -128 -> X0 = (-262144, 0) and every other bin = (0, 0), with no overflow.
REQ-026 Impulse, x[0] = 127 and the rest 0 -> every bin = (32512, 0).
REQ-027 Back-to-back: iStart high for 3 consecutive cycles with distinct sample sets -> 3 consecutive oDone pulses, each result set correct and in order.
REQ-028 Reset asserted one cycle after a capture -> no oDone pulse and oResult* = 0. A subsequent capture completes normally.
